// File: rtl/huffman_pkg.sv
// Shared types and defaults for the Huffman decoder slice.
// Symbol alphabet, FSM states and field widths.
package huffman_pkg;

    localparam int N_SYM_DEF   = 8;
    localparam int MAX_LEN_DEF = 7;
    localparam int LEN_W       = 3;
    localparam int CHAR_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    typedef enum logic [CHAR_W-1:0] {
        SYM_A = 3'd0,
        SYM_B = 3'd1,
        SYM_C = 3'd2,
        SYM_E = 3'd3,
        SYM_I = 3'd4,
        SYM_L = 3'd5,
        SYM_O = 3'd6,
        SYM_V = 3'd7
    } sym_e;

endpackage

// File: rtl/huffman_decoder_if.sv
// Table-load, serial-bit and decoded-symbol bundle.
// master drives table/bits, slave is the decoder.
interface huffman_decoder_if
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF
);
    logic               tbl_valid;
    logic [MAX_LEN-1:0] tbl_code;
    logic [LEN_W-1:0]   tbl_len;
    logic               bit_valid;
    logic               bit_in;
    logic               bit_last;
    logic               out_valid;
    logic [CHAR_W-1:0]  out_char;
    logic               out_last;
    logic               err;
    logic               busy;

    modport master (
        output tbl_valid, tbl_code, tbl_len,
        output bit_valid, bit_in, bit_last,
        input  out_valid, out_char, out_last,
        input  err, busy
    );

    modport slave (
        input  tbl_valid, tbl_code, tbl_len,
        input  bit_valid, bit_in, bit_last,
        output out_valid, out_char, out_last,
        output err, busy
    );
endinterface

// File: rtl/huff_match.sv
// Combinational candidate-vs-table comparator.
// Returns hit and the lowest matching index.
module huff_match
    import huffman_pkg::*;
#(
    parameter int N_SYM   = N_SYM_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic [MAX_LEN-1:0] cand,
    input  logic [LEN_W-1:0]   cand_len,
    input  logic [MAX_LEN-1:0] code [N_SYM],
    input  logic [LEN_W-1:0]   len  [N_SYM],
    output logic               hit,
    output logic [CHAR_W-1:0]  idx
);
    logic [MAX_LEN-1:0] mask;

    // Only the low cand_len bits of a right-aligned code are significant.
    assign mask = ~({MAX_LEN{1'b1}} << cand_len);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N_SYM - 1; i >= 0; i--) begin
            if (len[i] == cand_len &&
                ((code[i] ^ cand) & mask) == '0) begin
                hit = 1'b1;
                idx = CHAR_W'(i);
            end
        end
    end
endmodule

// File: rtl/huffman_decoder.sv
// Table-driven serial Huffman decoder.
// Loads N_SYM codes, then decodes one symbol per completing bit.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int N_SYM   = N_SYM_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input logic              clk,
    input logic              rst_n,
    huffman_decoder_if.slave bus
);
    localparam int IDX_W = (N_SYM > 1) ? $clog2(N_SYM) : 1;

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] LOAD   = ST_LOAD;
    localparam logic [1:0] DECODE = ST_DECODE;

    logic [1:0]         state;
    logic [IDX_W-1:0]   ent;
    logic [MAX_LEN-2:0] acc;
    logic [LEN_W-1:0]   cnt;
    logic [MAX_LEN-1:0] code_q [N_SYM];
    logic [LEN_W-1:0]   len_q  [N_SYM];

    logic [MAX_LEN-1:0] cand;
    logic [LEN_W-1:0]   cand_len;
    logic               hit;
    logic [CHAR_W-1:0]  hit_idx;
    logic               full;
    logic               last_ent;
    logic               tbl_wr;
    logic [IDX_W-1:0]   wr_idx;

    logic               out_valid_q;
    logic [CHAR_W-1:0]  out_char_q;
    logic               out_last_q;
    logic               err_q;

    assign cand     = {acc, bus.bit_in};
    assign cand_len = cnt + 1'b1;
    assign full     = (cand_len == LEN_W'(MAX_LEN));
    assign last_ent = (ent == IDX_W'(N_SYM - 1));
    assign tbl_wr   = bus.tbl_valid &&
                      (state == IDLE || state == LOAD);
    assign wr_idx   = (state == IDLE) ? '0 : ent;

    huff_match #(
        .N_SYM   (N_SYM),
        .MAX_LEN (MAX_LEN)
    ) u_match (
        .cand     (cand),
        .cand_len (cand_len),
        .code     (code_q),
        .len      (len_q),
        .hit      (hit),
        .idx      (hit_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SYM; i++) begin
                code_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (tbl_wr) begin
            code_q[wr_idx] <= bus.tbl_code;
            len_q[wr_idx]  <= bus.tbl_len;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ent         <= '0;
            acc         <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.tbl_valid) begin
                        ent   <= IDX_W'(1);
                        state <= (N_SYM == 1) ? DECODE : LOAD;
                    end
                end
                LOAD: begin
                    if (bus.tbl_valid) begin
                        if (last_ent) begin
                            ent   <= '0;
                            state <= DECODE;
                        end else begin
                            ent <= ent + 1'b1;
                        end
                    end
                end
                DECODE: begin
                    if (bus.bit_valid) begin
                        if (hit) begin
                            out_valid_q <= 1'b1;
                            out_char_q  <= hit_idx;
                            out_last_q  <= bus.bit_last;
                            acc         <= '0;
                            cnt         <= '0;
                        end else if (bus.bit_last || full) begin
                            err_q <= 1'b1;
                            acc   <= '0;
                            cnt   <= '0;
                        end else begin
                            acc <= cand[MAX_LEN-2:0];
                            cnt <= cand_len;
                        end
                        if (bus.bit_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign bus.out_last  = out_last_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed frames plus random
// streams checked against a bit-string prefix-match model.
module tb_huffman_decoder;
    import huffman_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    huffman_decoder_if #(.MAX_LEN(7)) bus();

    huffman_decoder #(.N_SYM(8), .MAX_LEN(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int t_code [8];
    int t_len  [8];
    int m_code [8];
    int m_len  [8];
    bit m_act = 1'b0;
    int p_val = 0;
    int p_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".valid"}, 32'(bus.out_valid), 0);
        chk({tag, ".char"}, 32'(bus.out_char), 0);
        chk({tag, ".last"}, 32'(bus.out_last), 0);
        chk({tag, ".err"}, 32'(bus.err), 0);
    endtask

    task automatic set_std();
        for (int i = 0; i < 8; i++) begin
            t_len[i]  = (i == 7) ? 7 : i + 1;
            t_code[i] = (1 << t_len[i]) - 2;
        end
        t_code[7] = 127;
    endtask

    task automatic idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.bit_valid = 1'b0;
            bus.bit_last  = 1'b0;
            bus.tbl_valid = 1'b0;
            @(posedge clk);
            #1;
            chk_quiet(tag);
            chk({tag, ".busy"}, 32'(bus.busy), 32'(m_act));
        end
    endtask

    task automatic send_bit(input bit b, input bit last,
                            input string tag);
        int hit;
        bit ev, el, ee;
        int ec;
        @(negedge clk);
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        bus.bit_last  = last;
        @(posedge clk);
        #1;
        ev = 0; el = 0; ee = 0; ec = 0;
        if (m_act) begin
            p_val = p_val * 2 + int'(b);
            p_len++;
            hit = -1;
            for (int i = 0; i < 8; i++)
                if (hit < 0 && m_len[i] == p_len &&
                    (m_code[i] % (1 << p_len)) == p_val)
                    hit = i;
            if (hit >= 0) begin
                ev = 1; ec = hit; el = last;
            end else if (last || p_len == 7) begin
                ee = 1;
            end
            if (hit >= 0 || ee) begin
                p_val = 0; p_len = 0;
            end
            if (last) m_act = 0;
        end
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
        chk({tag, ".char"}, 32'(bus.out_char), 32'(ec));
        chk({tag, ".last"}, 32'(bus.out_last), 32'(el));
        chk({tag, ".err"}, 32'(bus.err), 32'(ee));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_act));
    endtask

    task automatic load_tbl(input int gap_at, input int abort_at,
                            input string tag);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                @(negedge clk);
                bus.tbl_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                chk_quiet({tag, ".rst"});
                chk({tag, ".rst.busy"}, 32'(bus.busy), 0);
                for (int j = 0; j < 8; j++) m_len[j] = 0;
                m_act = 0; p_val = 0; p_len = 0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                chk_quiet({tag, ".post"});
                chk({tag, ".post.busy"}, 32'(bus.busy), 0);
                return;
            end
            if (i == gap_at && i > 0) begin
                @(negedge clk);
                bus.tbl_valid = 1'b0;
                @(posedge clk);
                #1;
                chk({tag, ".gap.busy"}, 32'(bus.busy), 1);
            end
            @(negedge clk);
            bus.tbl_valid = 1'b1;
            bus.tbl_code  = 7'(t_code[i]);
            bus.tbl_len   = 3'(t_len[i]);
            @(posedge clk);
            #1;
            chk({tag, ".busy"}, 32'(bus.busy), 1);
        end
        @(negedge clk);
        bus.tbl_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            m_code[j] = t_code[j];
            m_len[j]  = t_len[j];
        end
        m_act = 1; p_val = 0; p_len = 0;
    endtask

    initial begin
        int nb;
        bus.tbl_valid = 1'b0;
        bus.tbl_code  = '0;
        bus.tbl_len   = '0;
        bus.bit_valid = 1'b0;
        bus.bit_in    = 1'b0;
        bus.bit_last  = 1'b0;
        #2;
        chk_quiet("reset");
        chk("reset.busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        send_bit(1'b0, 1'b1, "idle_bit");
        idle(1, "idle_q");

        // Basic stream 0,10,1111111 with a tbl_valid gap in LOAD
        set_std();
        load_tbl(3, -1, "ld1");
        @(negedge clk);
        bus.tbl_valid = 1'b1;
        bus.tbl_code  = '0;
        bus.tbl_len   = '0;
        @(posedge clk);
        #1;
        chk("dec_tbl.busy", 32'(bus.busy), 1);
        chk_quiet("dec_tbl");
        send_bit(1'b0, 1'b0, "s1.b0");
        send_bit(1'b1, 1'b0, "s2.b0");
        send_bit(1'b0, 1'b0, "s2.b1");
        for (int k = 0; k < 6; k++) send_bit(1'b1, 1'b0, "s3.b");
        send_bit(1'b1, 1'b1, "s3.last");
        idle(2, "s_end");

        // Bits spread out with bit_valid gaps
        load_tbl(-1, -1, "ld2");
        send_bit(1'b1, 1'b0, "gap.b0");
        idle(3, "gap.i0");
        send_bit(1'b1, 1'b0, "gap.b1");
        idle(3, "gap.i1");
        send_bit(1'b0, 1'b1, "gap.b2");
        idle(2, "gap.end");

        // Unused idx6 forces an error at MAX_LEN
        t_len[6] = 0;
        load_tbl(-1, -1, "ld3");
        for (int k = 0; k < 6; k++) send_bit(1'b1, 1'b0, "e7.b");
        send_bit(1'b0, 1'b0, "e7.b6");
        send_bit(1'b0, 1'b1, "e7.after");
        idle(1, "e7.end");
        set_std();

        // Frame ends on a partial code
        load_tbl(-1, -1, "ld4");
        send_bit(1'b1, 1'b0, "pl.b0");
        send_bit(1'b1, 1'b1, "pl.b1");
        idle(2, "pl.end");

        // Reset in the middle of a load, then a fresh load
        load_tbl(-1, 4, "ld5");
        load_tbl(-1, -1, "ld6");
        send_bit(1'b0, 1'b1, "rl.b0");
        idle(1, "rl.end");

        // Duplicate codes resolve to the lowest index
        t_len[0] = 0;
        t_len[1] = 0;
        t_code[2] = 0; t_len[2] = 1;
        t_code[5] = 0; t_len[5] = 1;
        load_tbl(-1, -1, "ld7");
        send_bit(1'b0, 1'b1, "dup.b0");
        idle(1, "dup.end");

        for (int f = 0; f < 6; f++) begin
            set_std();
            if (f % 2 == 1)
                for (int i = 0; i < 8; i++) begin
                    t_len[i]  = int'($urandom_range(0, 7));
                    t_code[i] = int'($urandom_range(0, 127));
                end
            load_tbl(int'($urandom_range(1, 7)), -1, "rnd.ld");
            nb = int'($urandom_range(5, 30));
            for (int k = 0; k < nb; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1, "rnd.idle");
                send_bit(1'($urandom), k == nb - 1, "rnd.bit");
            end
            idle(1, "rnd.end");
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/huffman_decoder.md
HUFFMAN_DECODER -- requirements
Module: huffman_decoder

Interface
REQ-001 SHALL have parameter N_SYM, default 8, meaning the number of symbols (character indices 0..N_SYM-1).
REQ-002 SHALL have parameter MAX_LEN, default 7, meaning the maximum code length in bits.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk input 1 is the rising-edge clock, and rst_n input 1 is the asynchronous active-low reset.
REQ-004 SHALL have tbl_valid input 1: table entry present this cycle.
REQ-005 SHALL have tbl_code input MAX_LEN: code bits, right-aligned, MSB transmitted first.
REQ-006 SHALL have tbl_len input 3: code length 1..MAX_LEN; a value of 0 marks the entry unused.
REQ-007 SHALL have bit_valid input 1: serial code bit present this cycle.
REQ-008 SHALL have bit_in input 1: serial code bit.
REQ-009 SHALL have bit_last input 1: the current bit is the final bit of the frame; qualified by bit_valid.
REQ-010 SHALL have out_valid output 1: one-cycle pulse marking a decoded symbol.
REQ-011 SHALL have out_char output 3: decoded symbol index.
REQ-012 SHALL have out_last output 1: set with the final decoded symbol of the frame.
REQ-013 SHALL have err output 1: one-cycle pulse marking an undecodable code.
REQ-014 SHALL have busy output 1: high while in LOAD or DECODE.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD and DECODE.
REQ-016 SHALL move IDLE->LOAD on the first tbl_valid; that entry is stored as index 0.
REQ-017 SHALL store N_SYM consecutive tbl_valid entries as indices 0..N_SYM-1; a tbl_valid gap in LOAD holds the entry counter without storing.
REQ-018 SHALL move LOAD->DECODE after entry N_SYM-1 is stored.
REQ-019 SHALL, in DECODE, shift each bit_valid bit into an accumulator (acc) and increment the bit count (cnt).
REQ-020 SHALL compare the candidate {acc,bit_in} of length cnt+1 against every entry with tbl_len == cnt+1 in the same cycle.
REQ-021 SHALL, on a match, pulse out_valid next cycle with out_char equal to the matching index and clear acc and cnt.
REQ-022 SHALL resolve multiple matches in favour of the lowest index.
REQ-023 SHALL, when cnt+1 == MAX_LEN and there is no match, pulse err next cycle and clear acc and cnt; decoding continues.
REQ-024 SHALL, on bit_last with a match, pulse out_valid and out_last together next cycle, then return to IDLE.
REQ-025 SHALL, on bit_last without a match, pulse err next cycle, discard the partial code and return to IDLE; out_valid is not asserted.
REQ-026 SHALL decode one symbol per cycle at most, with a latency of exactly 1 cycle from the completing bit to out_valid.
REQ-027 SHALL ignore bit_valid in IDLE and LOAD.
REQ-028 SHALL ignore tbl_valid in DECODE.
REQ-029 SHALL keep the stored table across frames until a new LOAD overwrites it.
REQ-030 SHALL drive out_char to 0 whenever out_valid is low.
REQ-031 SHALL drive out_last and err low except during their pulse cycles.

Reset
REQ-032 SHALL, on rst_n low, immediately set the state to IDLE, clear acc, cnt and the entry counter, and zero all table lengths.
REQ-033 SHALL drive out_valid=0, out_char=0, out_last=0, err=0 and busy=0 during reset.
REQ-034 SHALL, on reset mid-LOAD or mid-DECODE, abort the operation with no pending output pulse emitted after release.

Structure
REQ-035 SHALL place the state enum, N_SYM and MAX_LEN defaults, and the symbol encoding (A=0,B=1,C=2,E=3,I=4,L=5,O=6,V=7) in the shared package huffman_pkg.
REQ-036 SHALL contain exactly one sub-module, huff_match: a combinational comparator of the candidate against the table that returns a hit flag and the lowest matching index.

Verification
REQ-037 SHALL be covered by a bench that loads the table idx0=0/1, idx1=10/2, idx2=110/3, idx3=1110/4, idx4=11110/5, idx5=111110/6, idx6=1111110/7, idx7=1111111/7, sends stream 0,10,1111111 with last on the final bit, and checks out_char 0,1,7 with out_last on 7, each 1 cycle after its completing bit.
REQ-038 SHALL be covered by a bench that sends stream 1,1,0 with bit_valid low for 3 cycles between bits and checks a single out_char=2 with no spurious pulses.
REQ-039 SHALL be covered by a bench that, with idx6 set to len 0, sends 1111110 and checks an err pulse after bit 7, then checks that 0 decodes to out_char 0.
REQ-040 SHALL be covered by a bench that sends 1,1 with bit_last on the second bit and checks err=1, no out_valid, and busy=0 afterwards.
REQ-041 SHALL be covered by a bench that asserts rst_n low at entry 4 of LOAD and checks all outputs 0, then checks that a fresh load plus bit 0 (last) yields out_char 0 with out_last.
REQ-042 SHALL be covered by a bench that loads two entries both "0"/len1 at idx2 and idx5 and checks out_char=2.
